multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Upstream/downstream control stage for the 32-bit carry-lookahead adder. It accepts wide operands (32*WORDS bits) through a valid/ready handshake.
- It drives the adder one 32-bit slice per cycle, low slice first, holding the carry between slices in a register. It collects each slice sum and presents the full-width result through a valid/ready handshake.
- The adder stays a separate instance; the parent wires this block's add_* ports to it.

Parameters:
- WORDS, 2, number of 32-bit slices per operand; legal range 1..8; result width is 32*WORDS.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  32*WORDS  operand A.
- in_b  input  32*WORDS  operand B.
- in_cin  input  1  initial carry-in.
- add_a  output  32  A slice to the adder.
- add_b  output  32  B slice to the adder.
- add_cin  output  1  carry to the adder.
- add_sum  input  32  adder Sum, combinational return.
- add_cout  input  1  adder Cout, combinational return.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  32*WORDS  full-width sum.
- out_cout  output  1  final carry-out.
- out_ovf  output  1  signed overflow of the full-width add.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE, slice index to 0, and the carry, operand and sum registers to 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1.
  - Reset mid-operation aborts and discards the operation; no partial result is ever presented.
- FSM states are IDLE, RUN and DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready, latch in_a, in_b into registers and in_cin into the carry register, set idx=0, go to RUN.
  - RUN:
    - in_ready=0.
    - Drive add_a=a_reg[32*idx+:32], add_b=b_reg[32*idx+:32], add_cin=carry_reg.
    - Each edge, write add_sum into sum_reg[32*idx+:32], set carry_reg<=add_cout, idx<=idx+1.
    - When idx==WORDS-1, go to DONE after that capture.
  - DONE:
    - out_valid=1; out_sum=sum_reg; out_cout=carry_reg; out_ovf=(a_msb==b_msb)&&(sum_msb!=a_msb).
    - On out_ready, go to IDLE. There is no same-cycle accept of a new request in DONE (in_ready=0).
- Outside RUN, add_a=0, add_b=0, add_cin=0.
- Latency: out_valid rises exactly WORDS cycles after the accept edge. Throughput is one operation per WORDS+2 cycles with out_ready held high.
- out_sum, out_cout and out_ovf stay stable while out_valid=1 and out_ready=0. Input changes during RUN/DONE are ignored.
- Boundary cases:
  - WORDS=1: a single RUN cycle.
  - Carry ripple across every slice, e.g. all-ones+1, is handled through carry_reg.
  - The adder is combinational, so the block must not register add_a/add_b before the adder.
  - in_valid and out_ready may toggle freely; only the handshake edges matter.

Optional Feature:
- Macro SUBTRACT_EN.
- Defined:
  - Adds port in_sub (input, 1 bit), latched with the operands.
  - When in_sub=1, b_reg latches ~in_b and carry_reg latches 1, ignoring in_cin, so out_sum=A-B.
  - out_cout=1 means no borrow; out_ovf is computed on the inverted B.
- Undefined: the port is absent and the block only adds.

Decomposition:
- Shared package add_seq_pkg holds:
  - ADD_SLICE_W=32.
  - State typedef with IDLE/RUN/DONE.
  - WORDS_MAX=8.
  - An idx width function, clog2(WORDS_MAX).
- No sub-module: the slice mux and capture are inline. The 32-bit CLA remains an external sibling instance, wired in the parent.

Test Plan (WORDS=2, bench instantiates the 32-bit CLA on add_*):
- Operand-slice carry: A=0x00000000_FFFFFFFF, B=0x1, cin=0 -> out_sum=0x00000001_00000000, out_cout=0, out_valid 2 cycles after accept.
- Full ripple: A=B=0xFFFFFFFF_FFFFFFFF, cin=1 -> out_sum=0xFFFFFFFF_FFFFFFFF, out_cout=1, out_ovf=0.
- Signed overflow: A=0x7FFFFFFF_FFFFFFFF, B=0x1 -> out_sum=0x80000000_00000000, out_ovf=1, out_cout=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held at 1, outputs stable, in_ready=0; a new in_valid pulse is not accepted until one cycle after the out_ready handshake.
- Reset mid-RUN: assert rst after the first RUN edge -> out_valid=0, in_ready=1, add_*=0 immediately; a subsequent 3+4 gives 7.
- SUBTRACT_EN: A=5, B=7, in_sub=1 -> out_sum=0xFFFFFFFF_FFFFFFFE, out_cout=0; A=7, B=5 -> 2, out_cout=1.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared definitions for the multi-word add sequencer: slice width, FSM states
// and the width of the slice index.
package add_seq_pkg;

  localparam int ADD_SLICE_W = 32;
  localparam int WORDS_MAX   = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int idx_w();
    return $clog2(WORDS_MAX);
  endfunction

  localparam int IDX_W = idx_w();

endpackage

// File: rtl/multiword_add_sequencer.sv
// Feeds a 32-bit combinational adder one slice per cycle (low slice first),
// rippling the carry through a register. SUBTRACT_EN adds in_sub for A-B.
module multiword_add_sequencer
  import add_seq_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADD_SLICE_W*WORDS-1:0] in_a,
  input  logic [ADD_SLICE_W*WORDS-1:0] in_b,
  input  logic                         in_cin,
`ifdef SUBTRACT_EN
  input  logic                         in_sub,
`endif
  output logic [ADD_SLICE_W-1:0]       add_a,
  output logic [ADD_SLICE_W-1:0]       add_b,
  output logic                         add_cin,
  input  logic [ADD_SLICE_W-1:0]       add_sum,
  input  logic                         add_cout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADD_SLICE_W*WORDS-1:0] out_sum,
  output logic                         out_cout,
  output logic                         out_ovf
);

  localparam int SEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic [SEL_W-1:0]                     sel;
  logic [WORDS-1:0][ADD_SLICE_W-1:0]    a_reg, b_reg, sum_reg, sum_nxt;
  logic                                 carry_reg;
  logic [ADD_SLICE_W*WORDS-1:0]         b_lat;
  logic                                 cin_lat;

  assign sel = idx[SEL_W-1:0];

  // Subtraction is folded in at latch time: A + ~B + 1.
`ifdef SUBTRACT_EN
  assign b_lat   = in_sub ? ~in_b : in_b;
  assign cin_lat = in_sub ? 1'b1 : in_cin;
`else
  assign b_lat   = in_b;
  assign cin_lat = in_cin;
`endif

  // The adder is combinational, so slices go out unregistered.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    sum_nxt = sum_reg;
    sum_nxt[sel] = add_sum;
    if (state == RUN) begin
      add_a   = a_reg[sel];
      add_b   = b_reg[sel];
      add_cin = carry_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg     <= in_a;
            b_reg     <= b_lat;
            carry_reg <= cin_lat;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_nxt;
          carry_reg <= add_cout;
          if (idx == LAST) begin
            // Final slice: add_a/add_b carry the operand sign bits.
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            out_sum   <= sum_nxt;
            out_cout  <= add_cout;
            out_ovf   <= (add_a[ADD_SLICE_W-1] == add_b[ADD_SLICE_W-1]) &&
                         (add_sum[ADD_SLICE_W-1] != add_a[ADD_SLICE_W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (WORDS=2) with a behavioural
// 32-bit adder on the add_* ports.
module tb_multiword_add_sequencer;

  localparam int WORDS = 2;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0] in_a, in_b;
  logic [31:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef SUBTRACT_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge and let it be taken on the next posedge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    chk("in_ready_idle", W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_run", W'(in_ready), W'(0));
    chk("add_a_slice0", W'(add_a), W'(a[31:0]));
  endtask

  // Wait for out_valid (bounded), check latency and result, then handshake.
  task automatic finish_op(input string tag, input logic [W-1:0] esum, input logic ecout, input logic eovf);
    int n;
    for (n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) break;
    end
    chk({tag, "_latency"}, W'(n), W'(WORDS));
    chk({tag, "_sum"}, out_sum, esum);
    chk({tag, "_cout"}, W'(out_cout), W'(ecout));
    chk({tag, "_ovf"}, W'(out_ovf), W'(eovf));
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, W'(out_valid), W'(0));
    chk({tag, "_ready_back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] held_sum;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_sum", out_sum, W'(0));
    chk("rst_add_a", W'(add_a), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Carry out of the low slice into the high slice.
    start(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0);
    finish_op("slice_carry", 64'h00000001_00000000, 1'b0, 1'b0);

    // Carry ripples through every slice.
    start(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0);
    finish_op("ripple", 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0);

    // Positive + positive wraps negative.
    start(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0);
    finish_op("ovf", 64'h80000000_00000000, 1'b0, 1'b1);

    // Backpressure: hold out_ready low in DONE while a new request waits.
    start(64'h3, 64'h4, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_rise", W'(out_valid), W'(1));
    held_sum = out_sum;
    in_a = 64'h10; in_b = 64'h20; in_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid_hold", W'(out_valid), W'(1));
      chk("bp_sum_hold", out_sum, 64'h7);
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    chk("bp_sum_stable", out_sum, held_sum);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_no_same_cycle", W'(in_ready), W'(1));
    chk("bp_valid_drop", W'(out_valid), W'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", W'(in_ready), W'(0));
    chk("bp_add_a", W'(add_a), W'(32'h10));
    finish_op("bp_next", 64'h30, 1'b0, 1'b0);

    // Reset after the first RUN edge aborts the operation.
    start(64'h00000009_00000003, 64'h4, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_ready", W'(in_ready), W'(1));
    chk("mid_rst_add_a", W'(add_a), W'(0));
    chk("mid_rst_add_cin", W'(add_cin), W'(0));
    @(negedge clk);
    rst = 1'b0;
    start(64'h3, 64'h4, 1'b0, 1'b0);
    finish_op("after_rst", 64'h7, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    start(64'h5, 64'h7, 1'b0, 1'b1);
    finish_op("sub_neg", 64'hFFFFFFFF_FFFFFFFE, 1'b0, 1'b0);
    start(64'h7, 64'h5, 1'b0, 1'b1);
    finish_op("sub_pos", 64'h2, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
